// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to register the result.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,      // mult: {product_hi, product_lo}; div: {rem, quo}
  input  logic [WIDTH-1:0]   operand_i,  // multiplicand or divisor magnitude
  input  logic               bit_i,      // multiplier LSB or next dividend MSB
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_diff;

  // Sum and trial subtraction are WIDTH+1 bits wide so carry/borrow survive
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (bit_i ? {1'b0, operand_i} : '0);
    rem_sh    = {acc_i[2*WIDTH-1:WIDTH], bit_i};
    no_borrow = (rem_sh >= {1'b0, operand_i});
    // when no borrow the true difference is below the divisor, so WIDTH bits hold it
    rem_diff  = rem_sh[WIDTH-1:0] - operand_i;
    if (is_div_i) begin
      if (no_borrow) acc_o = {rem_diff,          acc_i[WIDTH-2:0], 1'b1};
      else           acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write port.
// Latency: start in cycle 0 -> done in cycle WIDTH+2 (2 for div-by-0 with MULDIV_DIV0_FLAG_EN).
// Backpressure: stall holds EX while busy; start/MT writes only honoured in IDLE/DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]   sh_q, sh_d;       // multiplier shifting right or dividend shifting left
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
  logic               div0_q, div0_d;
  logic               dz_q, dz_d;       // current op is a short-circuited divide by zero
`endif

  logic [2*WIDTH-1:0] step_acc;
  logic               step_bit;
  logic               can_accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;

  assign step_bit = div_q ? sh_q[WIDTH-1] : sh_q[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .bit_i     (step_bit),
    .is_div_i  (div_q),
    .acc_o     (step_acc)
  );

  // Next-state, operand capture, iteration and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    opnd_d   = opnd_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
    div0_d   = 1'b0;
    dz_d     = dz_q;
`endif
    can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

    // |-2^(W-1)| is 2^(W-1), which is exact as an unsigned WIDTH-bit magnitude
    a_neg = op_is_signed(op) & a[WIDTH-1];
    b_neg = op_is_signed(op) & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    prod_fix = negq_q ? (~acc_q + 1'b1) : acc_q;

    // MT writes land even alongside a start; the later result overwrites them
    if (can_accept && hi_we) hi_d = wdata;
    if (can_accept && lo_we) lo_d = wdata;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = op_is_div(op);
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          opnd_d  = op_is_div(op) ? b_mag : a_mag;
          sh_d    = op_is_div(op) ? a_mag : b_mag;
          acc_d   = '0;
`ifdef MULDIV_DIV0_FLAG_EN
          dz_d    = 1'b0;
          if (op_is_div(op) && (b == '0)) begin
            // preload the final answer and let FIX pass it straight through
            state_d = S_FIX;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            acc_d   = {a, {WIDTH{1'b1}}};
            dz_d    = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        sh_d  = div_q ? (sh_q << 1) : (sh_q >> 1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = negq_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          hi_d = negr_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
`ifdef MULDIV_DIV0_FLAG_EN
        div0_d = dz_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  // Single register stage for FSM, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      opnd_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      opnd_q  <= opnd_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q  <= div0_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q | (start & (state_q == S_IDLE));
`ifdef MULDIV_DIV0_FLAG_EN
  assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed test of the HI/LO multiply/divide sequencer.
// Latency: checks done at cycle 34 (or 2 for flagged divide by zero).
// Backpressure: checks stall window and MT writes dropped while busy.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div0;
`endif

  int          vecs = 0;
  int          errs = 0;
  int          lat;
  logic [63:0] stall_vec;
  logic        seen;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch an op (cycle 0) and return the cycle in which done rises, -1 on timeout.
  // b2b=1 means the caller is at the negedge of a DONE cycle and starts immediately.
  task automatic do_op(input bit b2b, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int l);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; a = x; b = y;
    l = -1;
    stall_vec = '0;
    for (int c = 0; c < 60; c++) begin
      if (!(b2b && c == 0)) @(negedge clk);
      stall_vec[c] = stall;
      if (done && c > 0) begin
        l = c;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);

    // 1: MULTU max*max
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_lat", lat, 34);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // 2: MULT -3*7 with stall window
    do_op(0, 2'b00, 32'hFFFF_FFFD, 32'd7, lat);
    chk("mult_lat", lat, 34);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_stall", stall_vec[34:0], 35'h3_FFFF_FFFF);
    chk("mult_busy_at_done", busy, 0);

    // signed corner cases with -2^31
    do_op(0, 2'b00, 32'h8000_0000, 32'h8000_0000, lat);
    chk("mult_min_min", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(0, 2'b00, 32'h8000_0000, 32'd1, lat);
    chk("mult_min_one", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

    // 3: DIV -7/2 and DIVU 100/7
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", lat, 34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    do_op(0, 2'b11, 32'd100, 32'd7, lat);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
`ifdef MULDIV_DIV0_FLAG_EN
    chk("divu_no_div0", div0, 0);
`endif
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);

    // 4: DIVU by zero
    do_op(0, 2'b11, 32'h0000_1234, 32'h0, lat);
`ifdef MULDIV_DIV0_FLAG_EN
    chk("div0_lat", lat, 2);
    chk("div0_flag", div0, 1);
`else
    chk("div0_lat", lat, 34);
`endif
    chk("div0_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

    // 5: reset at cycle 10 of a MULTU
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_busy", busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'hA5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi", hi, 32'hA5);

    // 6: start with simultaneous MTLO, MTHI while busy, then back-to-back start in DONE
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6; lo_we = 1'b1; wdata = 32'h77;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    chk("start_mtlo_lands", lo, 32'h77);
    chk("busy_run", busy, 1);
    @(posedge clk); #1;
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_dropped", hi, 32'hA5);
    lat = -1;
    for (int c = 3; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("mt_op_lat", lat, 34);
    chk("mt_op_hilo", {hi, lo}, 64'h0000_0000_0000_001E);
    do_op(1, 2'b11, 32'd100, 32'd7, lat);
    chk("b2b_lat", lat, 34);
    chk("b2b_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
